// File: rtl/hash_disp_pkg.sv
// Shared types and 7-segment encodings for the hash result front panel.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}.
package hash_disp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        SHOW,
        ERR
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0:    s = 8'hC0;
            4'h1:    s = 8'hF9;
            4'h2:    s = 8'hA4;
            4'h3:    s = 8'hB0;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h92;
            4'h6:    s = 8'h82;
            4'h7:    s = 8'hF8;
            4'h8:    s = 8'h80;
            4'h9:    s = 8'h90;
            4'hA:    s = 8'h88;
            4'hB:    s = 8'h83;
            4'hC:    s = 8'hC6;
            4'hD:    s = 8'hA1;
            4'hE:    s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchroniser, tick-qualified debounce and a
// one-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic sysclk_125mhz,
    input  logic rst,
    input  logic tick_i,
    input  logic btn_i,
    output logic rise_o
);

    localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

    logic [1:0]    sync_q;
    logic          level_q;
    logic          rise_q;
    logic [CW-1:0] cnt_q;

    // cnt_q counts down the remaining differing ticks needed before the level flips
    always_ff @(posedge sysclk_125mhz or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= CW'(DEBOUNCE_TICKS - 1);
        end else begin
            sync_q <= {sync_q[0], btn_i};
            rise_q <= 1'b0;
            if (tick_i) begin
                if (sync_q[1] == level_q) begin
                    cnt_q <= CW'(DEBOUNCE_TICKS - 1);
                end else if (cnt_q == '0) begin
                    cnt_q   <= CW'(DEBOUNCE_TICKS - 1);
                    level_q <= sync_q[1];
                    rise_q  <= sync_q[1];
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/hash_display_ctrl.sv
// Hash result front panel: start sequencing towards the hash core, digest
// latch and multiplexed 7-seg display with manual or auto-scrolled windows.
//
//  state | meaning
//  IDLE  | nothing requested since reset, display dark
//  START | one-cycle hash_start pulse to the core
//  WAIT  | waiting for hash_done, bounded by WAIT_MAX cycles
//  SHOW  | digest valid and displayed
//  ERR   | core timed out, dashes shown
module hash_display_ctrl
    import hash_disp_pkg::*;
#(
    parameter int HASH_W         = 256,
    parameter int NUM_DIGITS     = 4,
    parameter int DIV_REFRESH    = 100000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int SCROLL_TICKS   = 1000,
    parameter int WAIT_MAX       = 2**20,
    // may be widened so that out-of-range window selects are reachable
    parameter int SEL_W          = ($clog2(HASH_W / (4 * NUM_DIGITS)) > 0) ?
                                   $clog2(HASH_W / (4 * NUM_DIGITS)) : 1
) (
    input  logic                  sysclk_125mhz,
    input  logic                  rst,
    input  logic                  btn_start,
    input  logic                  btn_mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  hash_done,
    input  logic [HASH_W-1:0]     hash_in,
    output logic                  hash_start,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  busy,
    output logic [7:0]            led
);

    localparam int NUM_WIN = HASH_W / (4 * NUM_DIGITS);
    localparam int WIN_W   = (NUM_WIN > 1)      ? $clog2(NUM_WIN)      : 1;
    localparam int DIG_W   = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
    localparam int DIV_W   = (DIV_REFRESH > 1)  ? $clog2(DIV_REFRESH)  : 1;
    localparam int TMR_W   = (WAIT_MAX > 1)     ? $clog2(WAIT_MAX)     : 1;
    localparam int SCR_W   = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;

    state_t                  state_q;
    logic                    hash_start_q;
    logic                    busy_q;
    logic                    valid_q;
    logic                    err_q;
    logic                    auto_q;
    logic [HASH_W-1:0]       digest_q;
    logic [TMR_W-1:0]        tmr_q;
    logic [SCR_W-1:0]        scroll_q;
    logic [WIN_W-1:0]        win_q;
    logic [DIV_W-1:0]        div_q;
    logic [DIG_W-1:0]        digit_q;
    logic [DIG_W-1:0]        digit_d;
    logic [7:0]              seg_q;
    logic [7:0]              seg_d;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [NUM_DIGITS-1:0]   an_d;
    logic [7:0]              led_q;
    logic [31:0]             win_idx;
    logic                    win_ok;
    int                      nib_idx;
    logic                    tick;
    logic                    start_ev;
    logic                    mode_ev;

    assign tick = (div_q == DIV_W'(DIV_REFRESH - 1));

    btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_start (
        .sysclk_125mhz (sysclk_125mhz),
        .rst           (rst),
        .tick_i        (tick),
        .btn_i         (btn_start),
        .rise_o        (start_ev)
    );

    btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_mode (
        .sysclk_125mhz (sysclk_125mhz),
        .rst           (rst),
        .tick_i        (tick),
        .btn_i         (btn_mode),
        .rise_o        (mode_ev)
    );

    always_comb begin
        win_idx = auto_q ? 32'(win_q) : 32'(sel);
        win_ok  = (win_idx < 32'(NUM_WIN));
        digit_d = digit_q;
        if (tick) begin
            digit_d = (digit_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit_q + 1'b1;
        end
        nib_idx = win_ok ? (int'(win_idx) * NUM_DIGITS + int'(digit_d)) : 0;
        seg_d   = SEG_BLANK;
        an_d    = '1;
        if (state_q != IDLE) begin
            an_d = ~(NUM_DIGITS'(1) << digit_d);
            if (state_q == ERR) begin
                seg_d = SEG_DASH;
            end else if (win_ok) begin
                seg_d = hex_to_seg(digest_q[nib_idx*4 +: 4]);
            end
            if (auto_q && (digit_d == DIG_W'(NUM_DIGITS - 1))) begin
                seg_d[7] = 1'b0;
            end
        end
    end

    always_ff @(posedge sysclk_125mhz or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            hash_start_q <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            auto_q       <= 1'b0;
            digest_q     <= '0;
            tmr_q        <= '0;
            scroll_q     <= SCR_W'(SCROLL_TICKS - 1);
            win_q        <= '0;
            div_q        <= '0;
            digit_q      <= '0;
            seg_q        <= SEG_BLANK;
            an_q         <= '1;
            led_q        <= '0;
        end else begin
            hash_start_q <= 1'b0;
            div_q        <= tick ? '0 : div_q + 1'b1;
            digit_q      <= digit_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            led_q        <= {valid_q, err_q, busy_q, auto_q, win_idx[3:0]};

            if (tick && auto_q && (state_q == SHOW)) begin
                if (scroll_q == '0) begin
                    scroll_q <= SCR_W'(SCROLL_TICKS - 1);
                    win_q    <= (win_q == WIN_W'(NUM_WIN - 1)) ? '0 : win_q + 1'b1;
                end else begin
                    scroll_q <= scroll_q - 1'b1;
                end
            end

            case (state_q)
                IDLE, SHOW, ERR: begin
                    if (start_ev) begin
                        state_q      <= START;
                        hash_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                START: begin
                    state_q <= WAIT;
                    tmr_q   <= TMR_W'(WAIT_MAX - 1);
                end
                WAIT: begin
                    // done takes priority over a coincident timeout
                    if (hash_done) begin
                        state_q  <= SHOW;
                        digest_q <= hash_in;
                        valid_q  <= 1'b1;
                        err_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        win_q    <= '0;
                        scroll_q <= SCR_W'(SCROLL_TICKS - 1);
                    end else if (tmr_q == '0) begin
                        state_q <= ERR;
                        valid_q <= 1'b0;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (mode_ev) begin
                auto_q <= ~auto_q;
                if (!auto_q) begin
                    win_q    <= '0;
                    scroll_q <= SCR_W'(SCROLL_TICKS - 1);
                end
            end
        end
    end

    assign hash_start = hash_start_q;
    assign busy       = busy_q;
    assign seg        = seg_q;
    assign an         = an_q;
    assign led        = led_q;

endmodule

// File: tb/tb_hash_display_ctrl.sv
// Self-checking bench for hash_display_ctrl with small timing parameters.
module tb_hash_display_ctrl;

    localparam int HASH_W = 32;
    localparam int ND     = 4;
    localparam int NWIN   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_start;
    logic        btn_mode;
    logic [1:0]  sel;
    logic        hash_done;
    logic [31:0] hash_in;
    wire         hash_start;
    wire  [7:0]  seg;
    wire  [3:0]  an;
    wire         busy;
    wire  [7:0]  led;

    hash_display_ctrl #(
        .HASH_W(HASH_W), .NUM_DIGITS(ND), .DIV_REFRESH(4), .DEBOUNCE_TICKS(2),
        .SCROLL_TICKS(3), .WAIT_MAX(64), .SEL_W(2)
    ) dut (
        .sysclk_125mhz (clk),
        .rst           (rst),
        .btn_start     (btn_start),
        .btn_mode      (btn_mode),
        .sel           (sel),
        .hash_done     (hash_done),
        .hash_in       (hash_in),
        .hash_start    (hash_start),
        .seg           (seg),
        .an            (an),
        .busy          (busy),
        .led           (led)
    );

    always #4 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int hs_cycles = 0;

    always @(posedge clk) if (hash_start === 1'b1) hs_cycles++;

    typedef struct {
        logic [31:0]     digest;
        logic [1:0]      sel;
        logic [3:0][7:0] exp;
    } vec_t;

    vec_t tbl [6];

    logic [7:0] hexmap [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // reference: what digit k should show for a given digest/window/mode
    function automatic logic [7:0] exp_seg(input logic [31:0] d, input int w, input int k,
                                           input bit am, input bit er);
        logic [7:0] s;
        if (er) s = 8'hBF;
        else if (w >= NWIN) s = 8'hFF;
        else s = hexmap[int'((d >> (16 * w + 4 * k)) & 32'hF)];
        if (am && k == ND - 1) s[7] = 1'b0;
        return s;
    endfunction

    function automatic int digit_of(input logic [3:0] a);
        logic [3:0] m;
        for (int k = 0; k < ND; k++) begin
            m = ~(4'b0001 << k);
            if (a == m) return k;
        end
        return -1;
    endfunction

    task automatic check_scan(input string nm, input logic [31:0] d, input int w,
                              input bit am, input bit er, input int n);
        int k;
        logic [3:0] seen;
        seen = '0;
        for (int i = 0; i < n; i++) begin
            cyc(1);
            k = digit_of(an);
            chk({nm, "_an_onehot"}, 32'(k >= 0), 1);
            if (k >= 0) begin
                seen[k] = 1'b1;
                chk({nm, "_seg"}, 32'(seg), 32'(exp_seg(d, w, k, am, er)));
            end
        end
        chk({nm, "_all_digits"}, 32'(seen), 32'hF);
    endtask

    task automatic press(input bit s, input bit m);
        btn_start = s;
        btn_mode  = m;
        cyc(16);
        btn_start = 1'b0;
        btn_mode  = 1'b0;
        cyc(12);
    endtask

    task automatic run_hash(input logic [31:0] d);
        int h0;
        h0 = hs_cycles;
        press(1'b1, 1'b0);
        chk("start_pulse", 32'(hs_cycles - h0), 1);
        chk("busy_wait", 32'(busy), 1);
        hash_in   = d;
        hash_done = 1'b1;
        cyc(1);
        hash_done = 1'b0;
        hash_in   = ~d;
        cyc(3);
        chk("led_show", 32'(led[7:5]), 32'b100);
    endtask

    initial begin
        logic [31:0] d;
        int h0;
        int prev_w;
        int w;
        int since;
        int changes;

        tbl[0] = '{32'hDEADBEEF, 2'd0, {8'h83, 8'h86, 8'h86, 8'h8E}};
        tbl[1] = '{32'hDEADBEEF, 2'd1, {8'hA1, 8'h86, 8'h88, 8'hA1}};
        tbl[2] = '{32'hDEADBEEF, 2'd2, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        tbl[3] = '{32'hDEADBEEF, 2'd3, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        tbl[4] = '{32'h01234567, 2'd0, {8'h99, 8'h92, 8'h82, 8'hF8}};
        tbl[5] = '{32'h01234567, 2'd1, {8'hC0, 8'hF9, 8'hA4, 8'hB0}};

        rst = 1'b1; btn_start = 1'b0; btn_mode = 1'b0; sel = 2'd0;
        hash_done = 1'b0; hash_in = '0;
        cyc(3);
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_hs", 32'(hash_start), 0);
        chk("rst_led", 32'(led), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        cyc(5);

        h0 = hs_cycles;
        btn_start = 1'b1;
        cyc(2);
        btn_start = 1'b0;
        cyc(40);
        chk("glitch_no_start", 32'(hs_cycles - h0), 0);
        chk("idle_an", 32'(an), 32'hF);
        chk("idle_seg", 32'(seg), 32'hFF);

        foreach (tbl[i]) begin
            int k;
            run_hash(tbl[i].digest);
            sel = tbl[i].sel;
            cyc(2);
            chk("tbl_led_win", 32'(led[3:0]), 32'(tbl[i].sel));
            for (int c = 0; c < 16; c++) begin
                cyc(1);
                k = digit_of(an);
                chk("tbl_an_onehot", 32'(k >= 0), 1);
                if (k >= 0) chk("tbl_seg", 32'(seg), 32'(tbl[i].exp[k]));
            end
        end

        for (int r = 0; r < 4; r++) begin
            d = $urandom;
            run_hash(d);
            for (int s = 0; s < 4; s++) begin
                sel = 2'(s);
                cyc(2);
                chk("rnd_led_win", 32'(led[3:0]), 32'(s));
                check_scan("rnd", d, s, 1'b0, 1'b0, 16);
            end
        end

        press(1'b0, 1'b1);
        chk("auto_led", 32'(led[4]), 1);
        prev_w = int'(led[3:0]);
        since = 0;
        changes = 0;
        for (int c = 0; c < 74; c++) begin
            int k;
            cyc(1);
            since++;
            w = int'(led[3:0]);
            if (w != prev_w) begin
                chk("scroll_step", 32'(w), 32'((prev_w + 1) % NWIN));
                if (changes > 0) chk("scroll_period", 32'(since), 12);
                changes++;
                since = 0;
                prev_w = w;
            end
            k = digit_of(an);
            chk("auto_an_onehot", 32'(k >= 0), 1);
            if (k >= 0) chk("auto_seg", 32'(seg), 32'(exp_seg(d, w, k, 1'b1, 1'b0)));
        end
        chk("scroll_changes", 32'(changes >= 5), 1);

        sel = 2'd0;
        h0 = hs_cycles;
        press(1'b1, 1'b1);
        chk("both_start", 32'(hs_cycles - h0), 1);
        chk("both_manual", 32'(led[4]), 0);
        chk("both_busy", 32'(busy), 1);
        cyc(80);
        chk("err_led", 32'(led[7:5]), 32'b010);
        chk("err_busy", 32'(busy), 0);
        check_scan("err", d, 0, 1'b0, 1'b1, 16);
        h0 = hs_cycles;
        press(1'b1, 1'b0);
        chk("err_restart", 32'(hs_cycles - h0), 1);
        chk("err_restart_busy", 32'(busy), 1);

        h0 = hs_cycles;
        rst = 1'b1;
        cyc(3);
        chk("wrst_seg", 32'(seg), 32'hFF);
        chk("wrst_an", 32'(an), 32'hF);
        chk("wrst_led", 32'(led), 0);
        chk("wrst_busy", 32'(busy), 0);
        rst = 1'b0;
        hash_in = 32'h12345678;
        hash_done = 1'b1;
        cyc(1);
        hash_done = 1'b0;
        cyc(20);
        chk("post_rst_an", 32'(an), 32'hF);
        chk("post_rst_seg", 32'(seg), 32'hFF);
        chk("post_rst_led", 32'(led), 0);
        chk("post_rst_hs", 32'(hs_cycles - h0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
